// File: rtl/ls_pkg.sv
// rtl/ls_pkg.sv - shared load/store opcode, FSM state and width definitions
package ls_pkg;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [3:0] {
    LS_NONE = 4'd0,
    LB      = 4'd1,
    LBU     = 4'd2,
    LH      = 4'd3,
    LHU     = 4'd4,
    LW      = 4'd5,
    SB      = 4'd6,
    SH      = 4'd7,
    SW      = 4'd8
  } ls_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/ls_align.sv
// rtl/ls_align.sv - store lane/byte-enable generation, load extraction and misalign check
module ls_align
  import ls_pkg::*;
(
  input  logic [3:0]        lsop_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              is_load_o,
  output logic              is_store_o,
  output logic              misalign_o,
  output logic [BE_W-1:0]   be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] ld_data_o
);
  ls_op_t      op;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign op = ls_op_t'(lsop_i);

  always_comb begin
    ld_byte = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    ld_byte = rdata_i[15:8];
      2'd2:    ld_byte = rdata_i[23:16];
      2'd3:    ld_byte = rdata_i[31:24];
      default: ld_byte = rdata_i[7:0];
    endcase
  end

  assign ld_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    is_load_o  = 1'b0;
    is_store_o = 1'b0;
    misalign_o = 1'b0;
    be_o       = '0;
    wdata_o    = '0;
    ld_data_o  = '0;
    case (op)
      LB: begin
        is_load_o = 1'b1;
        be_o      = 4'b1111;
        ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      end
      LBU: begin
        is_load_o = 1'b1;
        be_o      = 4'b1111;
        ld_data_o = {24'd0, ld_byte};
      end
      LH: begin
        is_load_o  = 1'b1;
        misalign_o = addr_lo_i[0];
        be_o       = 4'b1111;
        ld_data_o  = {{16{ld_half[15]}}, ld_half};
      end
      LHU: begin
        is_load_o  = 1'b1;
        misalign_o = addr_lo_i[0];
        be_o       = 4'b1111;
        ld_data_o  = {16'd0, ld_half};
      end
      LW: begin
        is_load_o  = 1'b1;
        misalign_o = |addr_lo_i;
        be_o       = 4'b1111;
        ld_data_o  = rdata_i;
      end
      // Store data is replicated across lanes so memory only has to honour be_o.
      SB: begin
        is_store_o = 1'b1;
        be_o       = 4'b0001 << addr_lo_i;
        wdata_o    = {4{st_data_i[7:0]}};
      end
      SH: begin
        is_store_o = 1'b1;
        misalign_o = addr_lo_i[0];
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{st_data_i[15:0]}};
      end
      SW: begin
        is_store_o = 1'b1;
        misalign_o = |addr_lo_i;
        be_o       = 4'b1111;
        wdata_o    = st_data_i;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_ls_stage.sv
// rtl/mem_ls_stage.sv - MEM stage with req/ack data-memory port, stall, misalign and bus timeout
module mem_ls_stage
  import ls_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        lsop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              stallreq_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic              dm_req_o,
  output logic              dm_we_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [3:0]        dm_be_o,
  output logic [31:0]       dm_wdata_o,
  input  logic [31:0]       dm_rdata_i,
  input  logic              dm_ack_i
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] ld_q, ld_d;
  logic              err_q, err_d;

  logic              is_load, is_store, misalign;
  logic [BE_W-1:0]   al_be;
  logic [DATA_W-1:0] al_wdata, al_ld;

  ls_align u_align (
    .lsop_i     (lsop_i),
    .addr_lo_i  (mem_addr_i[1:0]),
    .st_data_i  (mem_wdata_i),
    .rdata_i    (dm_rdata_i),
    .is_load_o  (is_load),
    .is_store_o (is_store),
    .misalign_o (misalign),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .ld_data_o  (al_ld)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ld_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
    end
  end

  // EX/MEM inputs stay frozen while stallreq_o is high, so WAIT/DONE reuse them directly.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_d       = ld_q;
    err_d      = err_q;
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    stallreq_o = 1'b0;
    misalign_o = 1'b0;
    bus_err_o  = 1'b0;
    dm_req_o   = 1'b0;
    dm_we_o    = 1'b0;
    dm_addr_o  = '0;
    dm_be_o    = '0;
    dm_wdata_o = '0;
    if (!rst) begin
      wd_o       = wd_i;
      misalign_o = misalign;
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          err_d = 1'b0;
          if (!(is_load || is_store)) begin
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end else if (!misalign) begin
            stallreq_o = 1'b1;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          stallreq_o = 1'b1;
          dm_req_o   = 1'b1;
          dm_we_o    = is_store;
          dm_addr_o  = {mem_addr_i[ADDR_W-1:2], 2'b00};
          dm_be_o    = al_be;
          dm_wdata_o = al_wdata;
          cnt_d      = cnt_inc;
          // Ack is checked first so a response on the last allowed cycle still completes.
          if (dm_ack_i) begin
            if (is_load) ld_d = al_ld;
            cnt_d   = '0;
            state_d = DONE;
          end else if (cnt_inc == CNT_MAX) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
          if (err_q) begin
            bus_err_o = 1'b1;
          end else if (is_load) begin
            wreg_o  = wreg_i;
            wdata_o = ld_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ls_stage.sv
// tb/tb_mem_ls_stage.sv - randomized self-checking bench for mem_ls_stage against a behavioural model
module tb_mem_ls_stage;
  localparam int TO = 4;
  localparam int OP_NONE = 0, OP_LB = 1, OP_LBU = 2, OP_LH = 3, OP_LHU = 4, OP_LW = 5,
                 OP_SB = 6, OP_SH = 7, OP_SW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [3:0]  lsop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic        misalign_o;
  logic        bus_err_o;
  logic        dm_req_o;
  logic        dm_we_o;
  logic [31:0] dm_addr_o;
  logic [3:0]  dm_be_o;
  logic [31:0] dm_wdata_o;
  logic [31:0] dm_rdata_i;
  logic        dm_ack_i;

  int checks = 0;
  int failures = 0;

  mem_ls_stage #(.ADDR_W(32), .REG_AW(5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .lsop_i(lsop_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o), .dm_be_o(dm_be_o),
    .dm_wdata_o(dm_wdata_o), .dm_rdata_i(dm_rdata_i), .dm_ack_i(dm_ack_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit m_is_load(input int op);
    return op >= OP_LB && op <= OP_LW;
  endfunction

  function automatic bit m_is_store(input int op);
    return op >= OP_SB && op <= OP_SW;
  endfunction

  function automatic int m_size(input int op);
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    if (op == OP_LW || op == OP_SW) return 4;
    return 1;
  endfunction

  function automatic bit m_mis(input int op, input logic [31:0] a);
    return (m_is_load(op) || m_is_store(op)) && ((a % m_size(op)) != 0);
  endfunction

  function automatic logic [31:0] m_be(input int op, input logic [31:0] a);
    if (op == OP_SB) return 32'(1) << (a % 4);
    if (op == OP_SH) return 32'(3) << (a % 4);
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input int op, input logic [31:0] rt);
    if (op == OP_SB) return (rt & 32'hFF) * 32'h0101_0101;
    if (op == OP_SH) return (rt & 32'hFFFF) * 32'h0001_0001;
    return rt;
  endfunction

  function automatic logic [31:0] m_load(input int op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (8 * ((a % 4) & 2))) & 32'hFFFF;
    case (op)
      OP_LB:   return (b >= 128) ? b - 32'd256 : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32768) ? h - 32'd65536 : h;
      OP_LHU:  return h;
      default: return rd;
    endcase
  endfunction

  task automatic run_op(input int op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [4:0] wd, input logic wr, input logic [31:0] alu,
                        input int ack_at, input logic [31:0] rd);
    bit err;
    int stalls, nwait;
    lsop_i = op[3:0]; mem_addr_i = addr; mem_wdata_i = rt;
    wd_i = wd; wreg_i = wr; wdata_i = alu;
    dm_ack_i = 1'($urandom % 2); dm_rdata_i = $urandom;
    @(negedge clk);
    if (!(m_is_load(op) || m_is_store(op))) begin
      chk("pass_wd", wd_o, wd);
      chk("pass_wreg", wreg_o, wr);
      chk("pass_wdata", wdata_o, alu);
      chk("pass_stall", stallreq_o, 0);
      chk("pass_req", dm_req_o, 0);
      chk("pass_mis", misalign_o, 0);
      @(posedge clk); #1;
      return;
    end
    if (m_mis(op, addr)) begin
      chk("mis_flag", misalign_o, 1);
      chk("mis_wreg", wreg_o, 0);
      chk("mis_stall", stallreq_o, 0);
      chk("mis_req", dm_req_o, 0);
      @(posedge clk); #1;
      return;
    end
    chk("op0_mis", misalign_o, 0);
    chk("op0_stall", stallreq_o, 1);
    chk("op0_req", dm_req_o, 0);
    stalls = int'(stallreq_o);
    @(posedge clk); #1;
    err = 1'b0;
    nwait = 0;
    for (int i = 1; i <= TO; i++) begin
      dm_ack_i   = (i == ack_at);
      dm_rdata_i = (i == ack_at) ? rd : $urandom;
      @(negedge clk);
      nwait++;
      stalls += int'(stallreq_o);
      chk("wait_req", dm_req_o, 1);
      chk("wait_we", dm_we_o, m_is_store(op));
      chk("wait_addr", dm_addr_o, addr & ~32'd3);
      chk("wait_be", dm_be_o, m_is_store(op) ? m_be(op, addr) : 32'd15);
      if (m_is_store(op)) chk("wait_wdata", dm_wdata_o, m_wdata(op, rt));
      chk("wait_berr", bus_err_o, 0);
      @(posedge clk); #1;
      if (i == ack_at) break;
      if (i == TO) err = 1'b1;
    end
    dm_ack_i = 1'($urandom % 2); dm_rdata_i = $urandom;
    @(negedge clk);
    chk("done_stall", stallreq_o, 0);
    chk("done_req", dm_req_o, 0);
    chk("done_berr", bus_err_o, err);
    chk("done_wreg", wreg_o, (m_is_load(op) && !err) ? wr : 1'b0);
    chk("done_wd", wd_o, wd);
    if (m_is_load(op) && !err) chk("done_load", wdata_o, m_load(op, addr, rd));
    chk("stall_cycles", stalls, 1 + nwait);
    chk("wait_cycles", nwait, err ? TO : ack_at);
    @(posedge clk); #1;
    dm_ack_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF; lsop_i = 4'd5;
    mem_addr_i = 32'h100; mem_wdata_i = 32'h1; dm_rdata_i = '0; dm_ack_i = 1'b1;
    @(negedge clk);
    chk("rst_wd", wd_o, 0);
    chk("rst_wreg", wreg_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_stall", stallreq_o, 0);
    chk("rst_req", dm_req_o, 0);
    chk("rst_be", dm_be_o, 0);
    @(posedge clk); #1;
    rst = 1'b0; dm_ack_i = 1'b0;

    run_op(OP_NONE, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234, 0, 32'h0);
    run_op(OP_LB,  32'h1003, 32'h0, 5'd7, 1'b1, 32'h0, 3, 32'h80FF_FF7F);
    run_op(OP_LBU, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h0, 3, 32'h80FF_FF7F);
    run_op(OP_SH,  32'h2002, 32'hAAAA_BEEF, 5'd4, 1'b1, 32'h0, 1, 32'h0);
    run_op(OP_LW,  32'h2001, 32'h0, 5'd4, 1'b1, 32'h0, 1, 32'h0);
    run_op(OP_LW,  32'h3000, 32'h0, 5'd5, 1'b1, 32'h0, 0, 32'h0);
    run_op(OP_LW,  32'h3004, 32'h0, 5'd5, 1'b1, 32'h0, TO, 32'hCAFE_F00D);
    run_op(OP_SB,  32'h4001, 32'h1234_56A5, 5'd1, 1'b1, 32'h0, 2, 32'h0);
    run_op(OP_LH,  32'h4002, 32'h0, 5'd2, 1'b1, 32'h0, 1, 32'h8001_7FFF);

    // Reset during WAIT abandons the request and a late ack must be ignored.
    lsop_i = 4'(OP_LW); mem_addr_i = 32'h5000; wd_i = 5'd6; wreg_i = 1'b1; dm_ack_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_req", dm_req_o, 0);
    chk("rstw_stall", stallreq_o, 0);
    chk("rstw_wreg", wreg_o, 0);
    chk("rstw_wd", wd_o, 0);
    chk("rstw_berr", bus_err_o, 0);
    @(posedge clk); #1;
    rst = 1'b0; lsop_i = 4'(OP_NONE); wdata_i = 32'h55AA; dm_ack_i = 1'b1;
    @(negedge clk);
    chk("post_req", dm_req_o, 0);
    chk("post_stall", stallreq_o, 0);
    chk("post_wdata", wdata_o, 32'h55AA);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post2_berr", bus_err_o, 0);
    chk("post2_wreg", wreg_o, 1);
    @(posedge clk); #1;
    dm_ack_i = 1'b0;

    for (int n = 0; n < 200; n++) begin
      run_op($urandom_range(0, 8), $urandom, $urandom, 5'($urandom), 1'($urandom),
             $urandom, $urandom_range(0, TO + 1), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
